// File: rtl/rr_sched_pkg.sv
// Shared definitions for the transaction-level round-robin scheduler.
// State encodings and the index-width helper used by rr_pick and rr_resource_scheduler.
package rr_sched_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked-priority picker: lowest set bit of req&mask, falling back to lowest set bit of req.
// Shared by the idle grant path and the release re-grant path of the scheduler.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] mask,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [WIDTH-1:0] w_masked;

    assign w_masked = req & mask;
    assign any      = |req;

    // Scan high-to-low so the last hit left standing is the lowest index.
    always_comb begin
        idx = '0;
        if (|w_masked) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (w_masked[i]) idx = IW'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_resource_scheduler.sv
// Round-robin scheduler that locks a grant for a whole multi-beat transaction.
// Define RR_SCHED_HOLD_TIMEOUT_EN to force release after MAX_HOLD beats without last.
module rr_resource_scheduler
    import rr_sched_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH-1:0]         last,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         gnt,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic                     gnt_valid,
    output logic                     beat,
    output logic                     timeout
);

    localparam int IW = idx_w(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || MAX_HOLD < 2) begin : g_param_chk
        $error("rr_resource_scheduler: WIDTH must be a power of two >= 2 and MAX_HOLD >= 2");
    end

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_gnt;
    logic [IW-1:0]    r_gnt_idx;
    logic             r_gnt_valid;
    logic [WIDTH-1:0] r_mask;

    logic [IW:0]      w_shamt;
    logic [WIDTH-1:0] w_rot_mask;
    logic [WIDTH-1:0] w_pick_mask;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_release;
    logic             w_force;
    logic             w_new_gnt;

    assign beat = r_gnt_valid & req[r_gnt_idx] & res_ready;

    // Mask after rotating past the current winner; the top index shifts it to zero.
    assign w_shamt     = {1'b0, r_gnt_idx} + {{IW{1'b0}}, 1'b1};
    assign w_rot_mask  = {WIDTH{1'b1}} << w_shamt;
    assign w_pick_mask = (r_state == ST_BUSY) ? w_rot_mask : r_mask;

    rr_pick #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_pick (
        .req  (req),
        .mask (w_pick_mask),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    assign w_release = (r_state == ST_BUSY) &
                       ((beat & last[r_gnt_idx]) | ~req[r_gnt_idx] | w_force);
    assign w_new_gnt = w_pick_any & ((r_state == ST_IDLE) | w_release);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_mask      <= '1;
        end else begin
            if (w_release) r_mask <= w_rot_mask;
            if (w_new_gnt) begin
                r_state     <= ST_BUSY;
                r_gnt_idx   <= w_pick_idx;
                r_gnt       <= {{(WIDTH - 1){1'b0}}, 1'b1} << w_pick_idx;
                r_gnt_valid <= 1'b1;
            end else if (w_release) begin
                r_state     <= ST_IDLE;
                r_gnt       <= '0;
                r_gnt_valid <= 1'b0;
            end
        end
    end

`ifdef RR_SCHED_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;

    logic [HW-1:0] r_hold_cnt;
    logic          r_timeout;

    assign w_force = beat & ~last[r_gnt_idx] & (r_hold_cnt == HW'(MAX_HOLD - 1));
    assign timeout = r_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_new_gnt) r_hold_cnt <= '0;
            else if (beat) r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule
